fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Producer side of the fetch-stage instruction register handshake. Holds the program counter, reads 36-bit instruction words from instruction memory, and drives each word onto the IR bus with a one-cycle IR_wr strobe. Advances the PC when the IR returns its PCenable acknowledge, or after a bounded timeout. The timeout covers back-to-back identical words, for which the IR raises no acknowledge. Supports a branch redirect that squashes any fetch in flight.

## Interface
Parameters:
- ADDR_W, 16, PC / memory address width
- INST_W, 36, instruction width
- RESET_PC, 0, PC value loaded on reset
- ACK_TIMEOUT, 4, cycles spent in ACK without pc_ack before forced advance (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable
- redirect  in  1  one-cycle branch redirect request
- redirect_pc  in  ADDR_W  redirect target
- mem_req  out  1  memory read strobe, one cycle
- mem_addr  out  ADDR_W  read address, valid with mem_req
- mem_valid  in  1  read data valid
- mem_rdata  in  INST_W  read data
- inst  out  INST_W  word for the IR bus
- inst_oe  out  1  bus drive enable; the top-level tristates inst with it
- IR_wr  out  1  IR write strobe
- pc_ack  in  1  PCenable from the IR
- pc  out  ADDR_W  current PC
- ack_timeout  out  1  one-cycle pulse on a forced advance

## Operation
- States: IDLE, REQ, WAIT, WRITE, ACK.
- IDLE → REQ when en=1.
- REQ: mem_req=1, mem_addr=pc for exactly one cycle → WAIT.
- WAIT: on mem_valid, capture mem_rdata into the word register → WRITE.
- WRITE: IR_wr=1, inst_oe=1, inst=word for one cycle → ACK. Clear the timeout counter.
- ACK: inst_oe stays 1 and inst is held. The timeout counter increments each cycle.
  - On pc_ack: pc ← pc+1.
  - If counter reaches ACK_TIMEOUT-1 without pc_ack: pc ← pc+1 and pulse ack_timeout.
  - After either, go to REQ if en=1, else IDLE.
- PC arithmetic: modulo 2^ADDR_W. 0xFFFF+1 wraps to 0x0000.
- Redirect, accepted in any state:
  - pc ← redirect_pc; no increment that cycle.
  - Redirect beats pc_ack and the timeout in the same cycle.
  - In WAIT: set the squash flag and stay in WAIT. On the next mem_valid, discard the data, clear squash, go REQ (or IDLE if en=0).
  - In REQ, WRITE or ACK: drop the current word, deassert inst_oe, go REQ (or IDLE if en=0).
  - In IDLE: load pc only.
- en deassert mid-fetch: the current instruction completes through ACK, then IDLE. No new REQ is issued.
- mem_valid outside WAIT is ignored.
- pc_ack outside ACK is ignored.

## Timing
- Reset (async) values:
  - state=IDLE
  - pc=RESET_PC
  - mem_req=0, mem_addr=0
  - inst=0, inst_oe=0
  - IR_wr=0
  - ack_timeout=0
  - squash=0, counter=0
- Reset mid-operation aborts immediately. A later mem_valid lands in IDLE and is ignored.
- All outputs are registered.
- Minimum instruction period is 4 cycles: REQ, WAIT (mem_valid the cycle after REQ), WRITE, ACK (pc_ack in the first ACK cycle).
- Expected IR acknowledge arrives 2 cycles after WRITE.
- Forced advance occurs ACK_TIMEOUT cycles after entering ACK.
- pc updates on the clock edge that leaves ACK. The new pc is visible on mem_addr in the following REQ cycle.

## Test plan
- Reset, en=1, RESET_PC=0x0010, memory returns 0x123456789 one cycle after each mem_req:
  - mem_addr=0x0010, then IR_wr pulses with inst=0x123456789.
  - pc_ack 2 cycles later → next mem_addr=0x0011.
- Two identical consecutive words with no pc_ack: ack_timeout pulses 4 cycles into ACK, then pc advances.
- redirect=1, redirect_pc=0x0200 while in WAIT:
  - The returned word is discarded with no IR_wr.
  - The next mem_addr is 0x0200.
- redirect and pc_ack in the same ACK cycle: pc becomes redirect_pc, not pc+1.
- pc=0xFFFF, acked → mem_addr=0x0000.
- rst asserted during WRITE: IR_wr, inst_oe and mem_req drop to 0 asynchronously, and pc=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: producer side of the fetch-stage IR handshake.
// Holds the PC, reads instruction words from memory, presents each word on
// the IR bus with a one-cycle IR_wr strobe, and advances the PC on the IR
// acknowledge or after a bounded wait. A branch redirect squashes any fetch
// in flight.
module fetch_sequencer #(
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        INST_W      = 36,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int unsigned        ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_oe,
  output logic              IR_wr,
  input  logic              pc_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              ack_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_ACK
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              squash;
  logic              squash_next;
  logic [3:0]        cnt;
  logic              capture;
  logic              fire_timeout;
  state_t            after_insn;

  // Where to go once the current instruction has finished or been dropped.
  always_comb begin
    after_insn = en ? S_REQ : S_IDLE;
  end

  // Next-state, next-PC and strobe decode; redirect overrides any PC update.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    squash_next  = squash;
    capture      = 1'b0;
    fire_timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en) state_next = S_REQ;
      end
      S_REQ: begin
        state_next = redirect ? after_insn : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          // Data arriving in the redirect cycle belongs to the old path.
          if (mem_valid) begin
            squash_next = 1'b0;
            state_next  = after_insn;
          end else begin
            squash_next = 1'b1;
          end
        end else if (mem_valid) begin
          if (squash) begin
            squash_next = 1'b0;
            state_next  = after_insn;
          end else begin
            capture    = 1'b1;
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        state_next = redirect ? after_insn : S_ACK;
      end
      S_ACK: begin
        if (redirect) begin
          state_next = after_insn;
        end else if (pc_ack) begin
          pc_next    = pc + ADDR_W'(1);
          state_next = after_insn;
        end else if (cnt == CNT_LAST) begin
          pc_next      = pc + ADDR_W'(1);
          fire_timeout = 1'b1;
          state_next   = after_insn;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (redirect) pc_next = redirect_pc;
  end

  // State, PC and squash flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      squash <= squash_next;
    end
  end

  // ACK wait counter: cleared while writing, counts each ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_WRITE) begin
      cnt <= '0;
    end else if (state == S_ACK) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Registered outputs, decoded from the upcoming state so each is aligned
  // with the cycle that state occupies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      inst        <= '0;
      inst_oe     <= 1'b0;
      IR_wr       <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      mem_req     <= (state_next == S_REQ);
      if (state_next == S_REQ) mem_addr <= pc_next;
      if (capture) inst <= mem_rdata;
      inst_oe     <= (state_next == S_WRITE) || (state_next == S_ACK);
      IR_wr       <= (state_next == S_WRITE);
      ack_timeout <= fire_timeout;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [35:0] mem_rdata = '0;
  logic [35:0] inst;
  logic        inst_oe;
  logic        IR_wr;
  logic        pc_ack = 1'b0;
  logic [15:0] pc;
  logic        ack_timeout;

  int unsigned tests = 0;
  int unsigned failed = 0;

  fetch_sequencer #(
    .ADDR_W(16),
    .INST_W(36),
    .RESET_PC(16'h0010),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .inst(inst),
    .inst_oe(inst_oe),
    .IR_wr(IR_wr),
    .pc_ack(pc_ack),
    .pc(pc),
    .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    tick;
    chk("rst_pc", 64'(pc), 64'h0010);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_inst_oe", 64'(inst_oe), 64'h0);
    chk("rst_IR_wr", 64'(IR_wr), 64'h0);
    chk("rst_ack_timeout", 64'(ack_timeout), 64'h0);
    rst = 1'b0;
    en  = 1'b1;

    // First fetch from RESET_PC, acknowledged two cycles after WRITE
    tick;
    chk("t1_req", 64'(mem_req), 64'h1);
    chk("t1_addr", 64'(mem_addr), 64'h0010);
    tick;
    chk("t1_wait_req", 64'(mem_req), 64'h0);
    mem_valid = 1'b1;
    mem_rdata = 36'h123456789;
    tick;
    mem_valid = 1'b0;
    chk("t1_irwr", 64'(IR_wr), 64'h1);
    chk("t1_oe", 64'(inst_oe), 64'h1);
    chk("t1_inst", 64'(inst), 64'h123456789);
    tick;
    chk("t1_ack0_irwr", 64'(IR_wr), 64'h0);
    chk("t1_ack0_oe", 64'(inst_oe), 64'h1);
    tick;
    pc_ack = 1'b1;
    tick;
    pc_ack = 1'b0;
    chk("t1_pc", 64'(pc), 64'h0011);
    chk("t1_next_req", 64'(mem_req), 64'h1);
    chk("t1_next_addr", 64'(mem_addr), 64'h0011);
    chk("t1_oe_off", 64'(inst_oe), 64'h0);
    chk("t1_no_timeout", 64'(ack_timeout), 64'h0);

    // Two identical words, no acknowledge: forced advance each time
    for (int k = 0; k < 2; k++) begin
      tick;
      mem_valid = 1'b1;
      mem_rdata = 36'hABCDE1234;
      tick;
      mem_valid = 1'b0;
      chk("t2_irwr", 64'(IR_wr), 64'h1);
      chk("t2_inst", 64'(inst), 64'hABCDE1234);
      tick;
      tick;
      tick;
      tick;
      chk("t2_ack3_oe", 64'(inst_oe), 64'h1);
      chk("t2_ack3_to", 64'(ack_timeout), 64'h0);
      chk("t2_ack3_pc", 64'(pc), 64'(16'h0011 + k));
      tick;
      chk("t2_to_pulse", 64'(ack_timeout), 64'h1);
      chk("t2_pc", 64'(pc), 64'(16'h0012 + k));
      chk("t2_addr", 64'(mem_addr), 64'(16'h0012 + k));
      chk("t2_req", 64'(mem_req), 64'h1);
    end

    // Redirect in WAIT: returned word squashed, refetch from target
    tick;
    chk("t3_to_cleared", 64'(ack_timeout), 64'h0);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    tick;
    redirect = 1'b0;
    chk("t3_pc", 64'(pc), 64'h0200);
    chk("t3_wait_req", 64'(mem_req), 64'h0);
    mem_valid = 1'b1;
    mem_rdata = 36'h00000DEAD;
    tick;
    mem_valid = 1'b0;
    chk("t3_no_irwr", 64'(IR_wr), 64'h0);
    chk("t3_no_oe", 64'(inst_oe), 64'h0);
    chk("t3_inst_kept", 64'(inst), 64'hABCDE1234);
    chk("t3_req", 64'(mem_req), 64'h1);
    chk("t3_addr", 64'(mem_addr), 64'h0200);

    // Redirect together with pc_ack in ACK: redirect wins
    tick;
    mem_valid = 1'b1;
    mem_rdata = 36'h111111111;
    tick;
    mem_valid = 1'b0;
    chk("t4_irwr", 64'(IR_wr), 64'h1);
    tick;
    pc_ack      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick;
    pc_ack   = 1'b0;
    redirect = 1'b0;
    chk("t4_pc", 64'(pc), 64'hFFFF);
    chk("t4_addr", 64'(mem_addr), 64'hFFFF);
    chk("t4_oe", 64'(inst_oe), 64'h0);

    // PC wrap on acknowledge at 0xFFFF
    tick;
    mem_valid = 1'b1;
    mem_rdata = 36'h222222222;
    tick;
    mem_valid = 1'b0;
    tick;
    pc_ack = 1'b1;
    tick;
    pc_ack = 1'b0;
    chk("t5_pc_wrap", 64'(pc), 64'h0000);
    chk("t5_addr_wrap", 64'(mem_addr), 64'h0000);

    // en dropped mid-fetch: instruction completes, then IDLE
    en = 1'b0;
    tick;
    mem_valid = 1'b1;
    mem_rdata = 36'h333333333;
    tick;
    mem_valid = 1'b0;
    chk("t6_irwr", 64'(IR_wr), 64'h1);
    chk("t6_inst", 64'(inst), 64'h333333333);
    tick;
    pc_ack = 1'b1;
    tick;
    pc_ack = 1'b0;
    chk("t6_pc", 64'(pc), 64'h0001);
    chk("t6_idle_req", 64'(mem_req), 64'h0);
    chk("t6_idle_oe", 64'(inst_oe), 64'h0);
    tick;
    chk("t6_idle_req2", 64'(mem_req), 64'h0);

    // Redirect in IDLE loads pc only; enable then fetches from it
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    tick;
    redirect = 1'b0;
    chk("t7_pc", 64'(pc), 64'h0300);
    chk("t7_req", 64'(mem_req), 64'h0);
    en = 1'b1;
    tick;
    chk("t7_req2", 64'(mem_req), 64'h1);
    chk("t7_addr", 64'(mem_addr), 64'h0300);

    // Asynchronous reset during WRITE
    tick;
    mem_valid = 1'b1;
    mem_rdata = 36'h444444444;
    tick;
    mem_valid = 1'b0;
    chk("t8_irwr_pre", 64'(IR_wr), 64'h1);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("t8_irwr", 64'(IR_wr), 64'h0);
    chk("t8_oe", 64'(inst_oe), 64'h0);
    chk("t8_req", 64'(mem_req), 64'h0);
    chk("t8_pc", 64'(pc), 64'h0010);
    tick;
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 36'h555555555;
    tick;
    mem_valid = 1'b0;
    chk("t8_stray_irwr", 64'(IR_wr), 64'h0);
    chk("t8_stray_oe", 64'(inst_oe), 64'h0);
    chk("t8_stray_inst", 64'(inst), 64'h0);
    chk("t8_stray_pc", 64'(pc), 64'h0010);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
